// File: rtl/tlul_sram_device_if.sv
// TL-UL A/D channel bundle between the peripheral crossbar (master) and an SRAM device (slave).
interface tlul_sram_device_if;
  logic        a_valid;
  logic [2:0]  a_opcode;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_ready;

  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic        d_sink;
  logic [31:0] d_data;
  logic [3:0]  d_user;
  logic        d_error;
  logic        d_ready;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_user, d_error
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_user, d_error
  );
endinterface

// File: rtl/tlul_sram_device.sv
// TL-UL device adapter onto a single-port SRAM with 1-cycle read latency.
// Requests are checked, issued to the SRAM, and responses queued in a Depth-entry FIFO.
module tlul_sram_device #(
  parameter int          MemAw    = 12,
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  parameter int          Depth    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  tlul_sram_device_if.slave tl,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MemAw-1:0]  mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [31:0]       mem_wmask_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  localparam int CW = $clog2(Depth + 1);
  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef struct packed {
    logic       is_get;
    logic [1:0] size;
    logic [7:0] source;
    logic       err;
  } meta_t;

  typedef struct packed {
    meta_t       meta;
    logic [31:0] data;
  } rsp_t;

  // ---------------- request checks ----------------
  logic       w_opc_ok, w_size_ok, w_in_range, w_aligned, w_mask_ok, w_err;
  logic [3:0] w_full_mask;

  assign w_opc_ok   = (tl.a_opcode == OP_GET) || (tl.a_opcode == OP_PUT_FULL) ||
                      (tl.a_opcode == OP_PUT_PART);
  assign w_size_ok  = (tl.a_size <= 2'd2);
  // Base is capacity-aligned, so the window test is an equality on the upper bits.
  assign w_in_range = (tl.a_address[31:MemAw+2] == BaseAddr[31:MemAw+2]);

  always_comb begin
    w_full_mask = 4'hF;
    w_aligned   = 1'b0;
    case (tl.a_size)
      2'd0: begin
        w_full_mask = 4'b0001 << tl.a_address[1:0];
        w_aligned   = 1'b1;
      end
      2'd1: begin
        w_full_mask = 4'b0011 << {tl.a_address[1], 1'b0};
        w_aligned   = ~tl.a_address[0];
      end
      2'd2: begin
        w_full_mask = 4'hF;
        w_aligned   = (tl.a_address[1:0] == 2'b00);
      end
      default: begin
        w_full_mask = 4'hF;
        w_aligned   = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_mask_ok = 1'b1;
    if (tl.a_opcode == OP_PUT_FULL)      w_mask_ok = (tl.a_mask == w_full_mask);
    else if (tl.a_opcode == OP_PUT_PART) w_mask_ok = ((tl.a_mask & ~w_full_mask) == 4'h0);
  end

  assign w_err = ~(w_opc_ok & w_size_ok & w_in_range & w_aligned & w_mask_ok);

  // ---------------- accept / occupancy ----------------
  logic          r_pv;
  meta_t         r_meta;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW:0]   w_occ;
  logic          w_a_ready, w_acc, w_push, w_pop;

  // Pipe entry counts against capacity so a slot is always free when it lands in the FIFO.
  assign w_occ     = {1'b0, r_count} + {{CW{1'b0}}, r_pv};
  assign w_a_ready = ~rst_i & (w_occ < (CW+1)'(Depth));
  assign w_acc     = tl.a_valid & w_a_ready;
  assign tl.a_ready = w_a_ready;

  // ---------------- SRAM port ----------------
  assign mem_req_o   = w_acc & ~w_err;
  assign mem_we_o    = (tl.a_opcode != OP_GET);
  assign mem_addr_o  = tl.a_address[MemAw+1:2];
  assign mem_wdata_o = tl.a_data;

  always_comb begin
    mem_wmask_o = '0;
    for (int b = 0; b < 4; b++) mem_wmask_o[8*b +: 8] = {8{tl.a_mask[b]}};
  end

  // ---------------- metadata pipe (cycle 1) ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pv   <= 1'b0;
      r_meta <= '0;
    end else begin
      r_pv <= w_acc;
      if (w_acc) begin
        r_meta.is_get <= (tl.a_opcode == OP_GET);
        r_meta.size   <= tl.a_size;
        r_meta.source <= tl.a_source;
        r_meta.err    <= w_err;
      end
    end
  end

  rsp_t w_rsp;
  assign w_push      = r_pv;
  assign w_rsp.meta  = r_meta;
  assign w_rsp.data  = (r_meta.is_get & ~r_meta.err) ? mem_rdata_i : 32'h0;

  // ---------------- response FIFO ----------------
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  rsp_t r_buf [Depth];
  rsp_t w_head;

  assign w_head = r_buf[r_rptr];
  assign w_pop  = (r_count != '0) & tl.d_ready;

  always_ff @(posedge clk_i) begin
    if (w_push) r_buf[r_wptr] <= w_rsp;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- D channel ----------------
  assign tl.d_valid  = (r_count != '0);
  assign tl.d_opcode = w_head.meta.is_get ? OP_ACK_DATA : OP_ACK;
  assign tl.d_param  = 3'd0;
  assign tl.d_size   = w_head.meta.size;
  assign tl.d_source = w_head.meta.source;
  assign tl.d_sink   = 1'b0;
  assign tl.d_data   = w_head.data;
  assign tl.d_user   = 4'd0;
  assign tl.d_error  = w_head.meta.err;

endmodule
